// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: byte-serial fetch from a 1-cycle byte memory, valid/ready out.
// Optional misaligned-redirect trap when IMEM_FETCH_ALIGN_CHECK_EN is defined.
module imem_fetch_ctrl #(
  parameter int                ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              fetch_fault
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_HOLD,
    S_FAULT
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_pc;
  logic [2:0]        r_cnt;
  logic [23:0]       r_asm;
  logic [31:0]       r_instr;
  logic [ADDR_W-1:0] r_ipc;
  logic              w_bad;
  logic              w_done;
  logic              w_accept;

`ifdef IMEM_FETCH_ALIGN_CHECK_EN
  assign w_bad = (redirect_pc[1:0] != 2'b00);
`else
  assign w_bad = 1'b0;
`endif

  // r_cnt==4 is the drain cycle: lane 3 arrives on rdata
  assign w_done   = (r_state == S_FETCH) &&
                    (r_cnt == 3'd4);
  assign w_accept = (r_state == S_HOLD) &&
                    instr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (1'b1)
      redirect_valid && w_bad:  w_next = S_FAULT;
      redirect_valid && !w_bad: w_next = S_FETCH;
      !redirect_valid && w_done:   w_next = S_HOLD;
      !redirect_valid && w_accept: w_next = S_FETCH;
      default: ;
    endcase
  end

  always_comb begin
    mem_addr    = r_pc;
    instr_valid = 1'b0;
    fetch_fault = 1'b0;
    unique case (r_state)
      S_FETCH: mem_addr = r_pc + ADDR_W'(r_cnt[1:0]);
      S_HOLD:  instr_valid = 1'b1;
      S_FAULT: fetch_fault = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_cnt   <= 3'd0;
      r_asm   <= 24'd0;
      r_instr <= 32'd0;
      r_ipc   <= '0;
    end else if (redirect_valid) begin
      r_pc  <= redirect_pc;
      r_cnt <= 3'd0;
    end else if (r_state == S_FETCH) begin
      case (r_cnt)
        3'd1: r_asm[7:0]   <= mem_rdata;
        3'd2: r_asm[15:8]  <= mem_rdata;
        3'd3: r_asm[23:16] <= mem_rdata;
        default: ;
      endcase
      if (w_done) begin
        r_instr <= {mem_rdata, r_asm};
        r_ipc   <= r_pc;
      end else begin
        r_cnt <= r_cnt + 3'd1;
      end
    end else if (w_accept) begin
      r_pc  <= r_pc + ADDR_W'(3'd4);
      r_cnt <= 3'd0;
    end
  end

  assign instr    = r_instr;
  assign instr_pc = r_ipc;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed vectors plus hand sequences for imem_fetch_ctrl.
// Byte memory model: mem[i] = i[7:0] except words at 0x000 and 0x004.
module tb_imem_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [9:0]  redirect_pc;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [9:0]  instr_pc;
  logic        fetch_fault;

  logic [7:0]  mem [1024];
  int          n_chk;
  int          n_fail;
  int          hs;
  int          hs0;

  typedef struct {
    int          rat;
    logic [9:0]  rpc;
    int          hold;
    logic [31:0] ei;
    logic [9:0]  ep;
  } vec_t;

  vec_t tv[6];

  imem_fetch_ctrl #(
    .ADDR_W  (10),
    .RESET_PC(10'h000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .fetch_fault   (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= mem[mem_addr];

  always @(posedge clk)
    if (rst_n && instr_valid && instr_ready)
      hs <= hs + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               nm, act, exp);
    end
  endtask

  task automatic wait_valid(input string nm,
                            input int lat,
                            input logic [31:0] ei,
                            input logic [9:0] ep);
    int c;
    logic [9:0] a;
    chk({nm, " addr0"}, 32'(mem_addr), 32'(ep));
    for (c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      if (c < 4) begin
        a = ep + 10'(c);
        chk($sformatf("%s addr%0d", nm, c),
            32'(mem_addr), 32'(a));
      end
      if (instr_valid) break;
    end
    chk({nm, " latency"}, 32'(c), 32'(lat));
    chk({nm, " instr"}, instr, ei);
    chk({nm, " pc"}, 32'(instr_pc), 32'(ep));
    chk({nm, " fault"}, 32'(fetch_fault), 32'd0);
  endtask

  task automatic accept(input string nm);
    instr_ready = 1'b1;
    @(posedge clk);
    #1;
    instr_ready = 1'b0;
    chk({nm, " valid drop"}, 32'(instr_valid), 32'd0);
  endtask

  task automatic redirect(input logic [9:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    hs = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
    mem[0] = 8'h13; mem[1] = 8'h05;
    mem[2] = 8'hA0; mem[3] = 8'h00;
    mem[4] = 8'h93; mem[5] = 8'h05;
    mem[6] = 8'h10; mem[7] = 8'h00;

    tv[0] = '{-1, 10'h000, 3, 32'h0B0A0908, 10'h008};
    tv[1] = '{ 2, 10'h040, 0, 32'h43424140, 10'h040};
    tv[2] = '{-1, 10'h000, 2, 32'h47464544, 10'h044};
`ifdef IMEM_FETCH_ALIGN_CHECK_EN
    tv[3] = '{ 0, 10'h3FC, 1, 32'hFFFEFDFC, 10'h3FC};
    tv[4] = '{-1, 10'h000, 0, 32'h00A00513, 10'h000};
`else
    tv[3] = '{ 0, 10'h3FE, 1, 32'h0513FFFE, 10'h3FE};
    tv[4] = '{-1, 10'h000, 0, 32'h059300A0, 10'h002};
`endif
    tv[5] = '{ 4, 10'h100, 1, 32'h03020100, 10'h100};

    rst_n = 1'b0;
    instr_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 10'h000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst valid", 32'(instr_valid), 32'd0);
    chk("rst instr", instr, 32'd0);
    chk("rst pc", 32'(instr_pc), 32'd0);
    chk("rst fault", 32'(fetch_fault), 32'd0);
    chk("rst addr", 32'(mem_addr), 32'd0);
    rst_n = 1'b1;

    wait_valid("t1", 5, 32'h00A00513, 10'h000);
    @(posedge clk);
    #1;
    chk("t1 accepted", 32'(instr_valid), 32'd0);
    wait_valid("t2", 5, 32'h00100593, 10'h004);
    instr_ready = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("t2 hold valid", 32'(instr_valid), 32'd1);
      chk("t2 hold instr", instr, 32'h00100593);
      chk("t2 hold pc", 32'(instr_pc), 32'h004);
      chk("t2 hold addr", 32'(mem_addr), 32'h004);
    end
    accept("t2");

    for (int i = 0; i < 6; i++) begin
      if (tv[i].rat >= 0) begin
        repeat (tv[i].rat) begin
          @(posedge clk);
          #1;
        end
        chk($sformatf("v%0d pre-redir", i),
            32'(instr_valid), 32'd0);
        redirect(tv[i].rpc);
      end
      wait_valid($sformatf("v%0d", i), 5,
                 tv[i].ei, tv[i].ep);
      repeat (tv[i].hold) begin
        @(posedge clk);
        #1;
        chk($sformatf("v%0d hold valid", i),
            32'(instr_valid), 32'd1);
        chk($sformatf("v%0d hold instr", i),
            instr, tv[i].ei);
        chk($sformatf("v%0d hold pc", i),
            32'(instr_pc), 32'(tv[i].ep));
        chk($sformatf("v%0d hold addr", i),
            32'(mem_addr), 32'(tv[i].ep));
      end
      accept($sformatf("v%0d", i));
    end

    wait_valid("t5a", 5, 32'h07060504, 10'h104);
    hs0 = hs;
    instr_ready = 1'b1;
    redirect(10'h080);
    instr_ready = 1'b0;
    chk("t5 valid drop", 32'(instr_valid), 32'd0);
    chk("t5 handshakes", 32'(hs - hs0), 32'd1);
    wait_valid("t5b", 5, 32'h83828180, 10'h080);
    accept("t5b");

    redirect(10'h200);
    redirect(10'h0C0);
    wait_valid("b2b", 5, 32'hC3C2C1C0, 10'h0C0);
    accept("b2b");

    redirect(10'h005);
`ifdef IMEM_FETCH_ALIGN_CHECK_EN
    chk("t6 fault set", 32'(fetch_fault), 32'd1);
    repeat (8) begin
      @(posedge clk);
      #1;
      chk("t6 fault valid", 32'(instr_valid), 32'd0);
      chk("t6 fault held", 32'(fetch_fault), 32'd1);
    end
    redirect(10'h008);
    chk("t6 fault clr", 32'(fetch_fault), 32'd0);
    wait_valid("t6", 5, 32'h0B0A0908, 10'h008);
`else
    chk("t6 no fault", 32'(fetch_fault), 32'd0);
    wait_valid("t6", 5, 32'h08001005, 10'h005);
`endif
    accept("t6");

    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("mrst valid", 32'(instr_valid), 32'd0);
    chk("mrst instr", instr, 32'd0);
    chk("mrst pc", 32'(instr_pc), 32'd0);
    chk("mrst fault", 32'(fetch_fault), 32'd0);
    chk("mrst addr", 32'(mem_addr), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_valid("mrst", 5, 32'h00A00513, 10'h000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
